// File: rtl/pong_round_sequencer.sv
// Purpose: frame-paced round controller for the paddle game. It steps each round
//   through IDLE, SERVE, PLAY, POINT and OVER, keeps both scores and drives the
//   winner code, ball gating (ball_run) and ball recentring (ball_load).
// Ports: clk (25 MHz pixel clock), reset (sync, active-low), frame_tick (screenEnd
//   level), start, goal_left, goal_right -> ball_run, ball_load (1-cycle pulse),
//   serve_dir, score_p1, score_p2, winner, state.
// Optional macro PONG_AUTO_RESTART_EN: OVER returns to IDLE after OVER_FRAMES ticks.
// Latency: every output is registered and changes one cycle after its cause.
module pong_round_sequencer #(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int OVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       goal_left,
  input  logic       goal_right,
  output logic       ball_run,
  output logic       ball_load,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [2:0] winner,
  output logic [2:0] state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] POINT = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  localparam logic [3:0] winScore   = 4'(WIN_SCORE);
  localparam logic [7:0] serveCount = 8'(SERVE_FRAMES);
  localparam logic [7:0] pointCount = 8'(POINT_FRAMES);
  localparam logic [7:0] overCount  = 8'(OVER_FRAMES);

  logic       frameTickQ;
  logic       tick;
  logic       cntDone;
  logic       goalLeftOnly;
  logic       goalRightOnly;
  logic [7:0] cnt;
  logic [7:0] cntNext;
  logic [2:0] stateNext;
  logic [3:0] scoreP1Next;
  logic [3:0] scoreP2Next;
  logic [2:0] winnerNext;
  logic       serveDirNext;
  logic       ballRunNext;
  logic       ballLoadNext;

  // screenEnd is a level that lasts many pixel clocks; only its rising edge counts.
  assign tick          = frame_tick & ~frameTickQ;
  assign cntDone       = tick && (cnt == 8'd1);
  // Both goals at once is treated as a glitch and scores nothing.
  assign goalLeftOnly  = goal_left & ~goal_right;
  assign goalRightOnly = goal_right & ~goal_left;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      frameTickQ <= 1'b0;
      cnt        <= 8'd0;
      score_p1   <= 4'd0;
      score_p2   <= 4'd0;
      winner     <= 3'd0;
      serve_dir  <= 1'b0;
      ball_run   <= 1'b0;
      ball_load  <= 1'b0;
    end else begin
      state      <= stateNext;
      frameTickQ <= frame_tick;
      cnt        <= cntNext;
      score_p1   <= scoreP1Next;
      score_p2   <= scoreP2Next;
      winner     <= winnerNext;
      serve_dir  <= serveDirNext;
      ball_run   <= ballRunNext;
      ball_load  <= ballLoadNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (start) stateNext = SERVE;
      SERVE: if (cntDone) stateNext = PLAY;
      PLAY:  if (goalLeftOnly || goalRightOnly) stateNext = POINT;
      POINT: begin
        if (cntDone) begin
          if ((score_p1 == winScore) || (score_p2 == winScore)) stateNext = OVER;
          else                                                  stateNext = SERVE;
        end
      end
      OVER: begin
        if (start) stateNext = SERVE;
`ifdef PONG_AUTO_RESTART_EN
        else if (cntDone) stateNext = IDLE;
`endif
      end
      default: stateNext = IDLE;
    endcase
  end

  // Next values of the registered outputs and the frame counter.
  always_comb begin
    ballRunNext  = (stateNext == PLAY);
    ballLoadNext = (stateNext == SERVE) && (state != SERVE);
    scoreP1Next  = score_p1;
    scoreP2Next  = score_p2;
    winnerNext   = winner;
    serveDirNext = serve_dir;

    // The counter reloads on every state change, so a tick in the cycle that
    // takes the transition is swallowed by the load. OVER always gets its
    // reload; it is only consumed when auto-restart is built in.
    if (stateNext != state) begin
      case (stateNext)
        SERVE:   cntNext = serveCount;
        POINT:   cntNext = pointCount;
        OVER:    cntNext = overCount;
        default: cntNext = 8'd0;
      endcase
    end else if (tick && (cnt != 8'd0)) begin
      cntNext = cnt - 8'd1;
    end else begin
      cntNext = cnt;
    end

    // A new game starts from IDLE or OVER.
    if (((state == IDLE) || (state == OVER)) && (stateNext == SERVE)) begin
      scoreP1Next  = 4'd0;
      scoreP2Next  = 4'd0;
      winnerNext   = 3'd0;
      serveDirNext = 1'b0;
    end

`ifdef PONG_AUTO_RESTART_EN
    if ((state == OVER) && (stateNext == IDLE)) begin
      scoreP1Next = 4'd0;
      scoreP2Next = 4'd0;
      winnerNext  = 3'd0;
    end
`endif

    // Scoring: the loser of the point receives the next serve.
    if (state == PLAY) begin
      if (goalLeftOnly) begin
        if (score_p2 < winScore) scoreP2Next = score_p2 + 4'd1;
        serveDirNext = 1'b1;
      end else if (goalRightOnly) begin
        if (score_p1 < winScore) scoreP1Next = score_p1 + 4'd1;
        serveDirNext = 1'b0;
      end
    end

    if ((state == POINT) && (stateNext == OVER)) begin
      winnerNext = (score_p1 == winScore) ? 3'd1 : 3'd2;
    end
  end

endmodule

// File: tb/tb_pong_round_sequencer.sv
module tb_pong_round_sequencer;

  localparam int WIN = 4;
  localparam int SF  = 3;
  localparam int PF  = 2;
  localparam int OF  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic       goal_left;
  logic       goal_right;
  logic       ball_run;
  logic       ball_load;
  logic       serve_dir;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [2:0] winner;
  logic [2:0] state;

  typedef struct packed {
    logic       run;
    logic       load;
    logic       dir;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [2:0] win;
    logic [2:0] st;
  } outs_t;

  typedef struct {
    logic  ft;
    logic  st;
    logic  gl;
    logic  gr;
    outs_t exp;
  } vec_t;

  outs_t expQ[$];
  int    compared   = 0;
  int    mismatched = 0;
  vec_t  vecs[15];

  pong_round_sequencer #(
    .WIN_SCORE   (WIN),
    .SERVE_FRAMES(SF),
    .POINT_FRAMES(PF),
    .OVER_FRAMES (OF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .start     (start),
    .goal_left (goal_left),
    .goal_right(goal_right),
    .ball_run  (ball_run),
    .ball_load (ball_load),
    .serve_dir (serve_dir),
    .score_p1  (score_p1),
    .score_p2  (score_p2),
    .winner    (winner),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic outs_t mk(input bit run, input bit load, input bit dir,
                               input int s1, input int s2, input int win, input int st);
    outs_t o;
    o.run  = run;
    o.load = load;
    o.dir  = dir;
    o.s1   = 4'(s1);
    o.s2   = 4'(s2);
    o.win  = 3'(win);
    o.st   = 3'(st);
    return o;
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, then pop
  // and compare once the DUT has registered its response.
  task automatic stepExp(input logic ft, input logic st, input logic gl, input logic gr,
                         input outs_t e, input string name);
    outs_t got;
    outs_t want;
    expQ.push_back(e);
    frame_tick = ft;
    start      = st;
    goal_left  = gl;
    goal_right = gr;
    @(posedge clk);
    #1;
    want = expQ.pop_front();
    got  = {ball_run, ball_load, serve_dir, score_p1, score_p2, winner, state};
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got run=%0b load=%0b dir=%0b p1=%0d p2=%0d win=%0d state=%0d, expected run=%0b load=%0b dir=%0b p1=%0d p2=%0d win=%0d state=%0d",
               name, got.run, got.load, got.dir, got.s1, got.s2, got.win, got.st,
               want.run, want.load, want.dir, want.s1, want.s2, want.win, want.st);
    end
  endtask

  // Starts in the first SERVE cycle; one quiet cycle, then SF tick pulses.
  task automatic serveWait(input int s1, input int s2, input bit dir);
    outs_t e;
    e = mk(0, 0, dir, s1, s2, 0, 1);
    stepExp(0, 0, 0, 0, e, "serve_lead");
    for (int i = 1; i <= SF; i++) begin
      if (i == SF) e = mk(1, 0, dir, s1, s2, 0, 2);
      stepExp(1, 0, 0, 0, e, "serve_tick");
      stepExp(0, 0, 0, 0, e, "serve_gap");
    end
  endtask

  // Starts in the first POINT cycle; fin is the state reached on the last tick.
  task automatic pointWait(input int s1, input int s2, input bit dir, input outs_t fin);
    outs_t e;
    e = mk(0, 0, dir, s1, s2, 0, 3);
    stepExp(0, 0, 0, 0, e, "point_lead");
    for (int i = 1; i <= PF; i++) begin
      if (i == PF) e = fin;
      stepExp(1, 0, 0, 0, e, "point_tick");
      if (i == PF) e.load = 1'b0;
      stepExp(0, 0, 0, 0, e, "point_gap");
    end
  endtask

  initial begin
    outs_t e;

    // Basic round walk-through: idle, start, serve count, play, goals, point.
    vecs[0]  = '{0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{0, 1, 0, 0, mk(0, 1, 0, 0, 0, 0, 1)};
    vecs[2]  = '{0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 1)};
    vecs[3]  = '{1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1)};
    vecs[4]  = '{1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1)};
    vecs[5]  = '{0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1)};
    vecs[6]  = '{1, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 1)};
    vecs[7]  = '{0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 1)};
    vecs[8]  = '{1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 2)};
    vecs[9]  = '{0, 1, 1, 1, mk(1, 0, 0, 0, 0, 0, 2)};
    vecs[10] = '{0, 0, 0, 1, mk(0, 0, 0, 1, 0, 0, 3)};
    vecs[11] = '{0, 0, 0, 1, mk(0, 0, 0, 1, 0, 0, 3)};
    vecs[12] = '{1, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 3)};
    vecs[13] = '{0, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 3)};
    vecs[14] = '{1, 0, 0, 0, mk(0, 1, 0, 1, 0, 0, 1)};

    reset = 1'b0;
    stepExp(1, 1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0), "reset_state");
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      stepExp(vecs[i].ft, vecs[i].st, vecs[i].gl, vecs[i].gr, vecs[i].exp,
              $sformatf("vec%0d", i));
    end

    // A frame_tick level held for 800 cycles is one tick, not many.
    e = mk(0, 0, 0, 1, 0, 0, 1);
    stepExp(0, 0, 0, 0, e, "serve_quiet");
    for (int i = 0; i < 800; i++) stepExp(1, 0, 0, 0, e, "tick_held");
    stepExp(0, 0, 0, 0, e, "held_release");
    stepExp(1, 0, 0, 0, e, "held_tick2");
    stepExp(0, 0, 0, 0, e, "held_gap2");
    stepExp(1, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 2), "held_tick3_play");

    // Player 2 wins 1:4.
    for (int k = 1; k < WIN; k++) begin
      stepExp(0, 0, 1, 0, mk(0, 0, 1, 1, k, 0, 3), "p2_goal");
      pointWait(1, k, 1, mk(0, 1, 1, 1, k, 0, 1));
      serveWait(1, k, 1);
    end
    stepExp(0, 0, 1, 0, mk(0, 0, 1, 1, WIN, 0, 3), "p2_final_goal");
    pointWait(1, WIN, 1, mk(0, 0, 1, 1, WIN, 2, 4));

    e = mk(0, 0, 1, 1, WIN, 2, 4);
    stepExp(0, 0, 0, 0, e, "over_lead");
`ifdef PONG_AUTO_RESTART_EN
    stepExp(1, 0, 0, 0, e, "over_tick1");
    stepExp(0, 0, 0, 0, e, "over_gap1");
    stepExp(1, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0), "auto_restart");
    stepExp(0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0), "idle_after_restart");
    stepExp(0, 1, 0, 0, mk(0, 1, 0, 0, 0, 0, 1), "start_from_idle");
`else
    for (int i = 0; i < OF + 2; i++) begin
      stepExp(1, 0, 0, 0, e, "over_hold_tick");
      stepExp(0, 0, 0, 0, e, "over_hold_gap");
    end
    stepExp(0, 1, 0, 0, mk(0, 1, 0, 0, 0, 0, 1), "restart_from_over");
`endif
    serveWait(0, 0, 0);

    // Player 1 reaches 3, then reset mid-play overrides start and goal.
    for (int k = 1; k <= 3; k++) begin
      stepExp(0, 0, 0, 1, mk(0, 0, 0, k, 0, 0, 3), "p1_goal");
      pointWait(k, 0, 0, mk(0, 1, 0, k, 0, 0, 1));
      serveWait(k, 0, 0);
    end
    reset = 1'b0;
    stepExp(1, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0), "reset_mid_play");
    reset = 1'b1;
    stepExp(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0), "idle_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
